// File: rtl/riscv_muldiv_pkg.sv
// riscv_muldiv_pkg: shared state encoding and func3 decode for the RV64M sequencer
package riscv_muldiv_pkg;
    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;
    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction
endpackage

// File: rtl/riscv_muldiv_sequencer_if.sv
// riscv_muldiv_sequencer_if: decoder/writeback handshake of the M-extension sequencer
interface riscv_muldiv_sequencer_if #(parameter int XLEN = 64);
    logic            start;
    logic            flush;
    logic [2:0]      func3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            busy;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] result;
    modport master(output start, flush, func3, op_a, op_b, input busy, stall, done, result);
    modport slave(input start, flush, func3, op_a, op_b, output busy, stall, done, result);
endinterface

// File: rtl/riscv_muldiv_step.sv
// riscv_muldiv_step: one radix-2 iteration, shift/add multiply or restoring divide
module riscv_muldiv_step #(parameter int XLEN = 64) (
    input  logic              div,
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   opnd,
    output logic [2*XLEN-1:0] acc_nx,
    output logic              q_bit
);
    logic [XLEN:0] sum;
    logic [XLEN:0] trial;
    always_comb begin
        sum    = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opnd : {XLEN{1'b0}})};
        trial  = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};
        q_bit  = div & ~trial[XLEN];
        // divide mode leaves the lsb clear; the caller merges q_bit into it
        acc_nx = div ? {(q_bit ? trial[XLEN-1:0] : acc[2*XLEN-2:XLEN-1]), acc[XLEN-2:0], 1'b0}
                     : {sum, acc[XLEN-1:1]};
    end
endmodule

// File: rtl/riscv_muldiv_sequencer.sv
// riscv_muldiv_sequencer: iterative RV64M controller; stalls the PC until the
// result is written back in a one-cycle done slot.
module riscv_muldiv_sequencer
    import riscv_muldiv_pkg::*;
#(parameter int XLEN = 64) (
    input logic clk,
    input logic reset,
    riscv_muldiv_sequencer_if.slave bus
);
    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic [XLEN-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
    logic [2*XLEN-1:0] acc_q, acc_d, acc_nx, prod;
    logic              na_q, na_d, nb_q, nb_d, done_q, done_d, busy_q, busy_d;
    logic              div, sa, sb, by_zero, ovf, q_bit;
    logic [XLEN-1:0]   quo, rem, fixed, special;

    riscv_muldiv_step #(.XLEN(XLEN)) u_step (
        .div(is_div(f3_q)), .acc(acc_q), .opnd(b_q), .acc_nx(acc_nx), .q_bit(q_bit)
    );

    always_comb begin
        div     = is_div(f3_q);
        sa      = f3_q == F3_MULH || f3_q == F3_MULHSU || f3_q == F3_DIV || f3_q == F3_REM;
        sb      = f3_q == F3_MULH || f3_q == F3_DIV || f3_q == F3_REM;
        by_zero = div && b_q == '0;
        ovf     = div && !f3_q[0] && a_q == MIN_NEG && b_q == '1;
        special = f3_q[1] ? (by_zero ? a_q : '0) : (by_zero ? '1 : a_q);
        prod    = (na_q ^ nb_q) ? -acc_q : acc_q;
        quo     = (na_q ^ nb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem     = na_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        fixed   = div ? (f3_q[1] ? rem : quo) : (f3_q == F3_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
        state_d = state_q;
        cnt_d   = cnt_q;
        f3_d    = f3_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        na_d    = na_q;
        nb_d    = nb_q;
        res_d   = res_q;
        case (state_q)
            IDLE: if (bus.start && !bus.flush) begin
                state_d = PREP;
                f3_d    = bus.func3;
                a_d     = bus.op_a;
                b_d     = bus.op_b;
            end
            PREP: begin
                na_d    = sa & a_q[XLEN-1];
                nb_d    = sb & b_q[XLEN-1];
                acc_d   = {{XLEN{1'b0}}, (na_d ? -a_q : a_q)};
                b_d     = nb_d ? -b_q : b_q;
                cnt_d   = '0;
                state_d = (by_zero || ovf) ? DONE : CALC;
                res_d   = (by_zero || ovf) ? special : res_q;
            end
            CALC: begin
                acc_d   = {acc_nx[2*XLEN-1:1], acc_nx[0] | q_bit};
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = cnt_q == CNT_W'(XLEN - 1) ? FIX : CALC;
            end
            FIX: begin
                res_d   = fixed;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        // a flush before DONE abandons the op; a DONE-cycle writeback is already committed
        if (bus.flush && state_q != IDLE && state_q != DONE) begin
            state_d = IDLE;
            res_d   = res_q;
        end
        done_d = state_d == DONE;
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            f3_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            na_q    <= 1'b0;
            nb_q    <= 1'b0;
            res_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            f3_q    <= f3_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            na_q    <= na_d;
            nb_q    <= nb_d;
            res_q   <= res_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = res_q;
    assign bus.stall  = (state_q == IDLE && bus.start && !bus.flush) || (busy_q && state_q != DONE);
endmodule

// File: tb/tb_riscv_muldiv_sequencer.sv
// tb_riscv_muldiv_sequencer: vector table plus scoreboard bench for the RV64M sequencer
module tb_riscv_muldiv_sequencer;
    import riscv_muldiv_pkg::*;
    localparam int XLEN = 64;
    localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct {
        logic [2:0]  f3;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;
    typedef struct {
        logic [63:0] exp;
        int          lat;
    } sb_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    riscv_muldiv_sequencer_if #(.XLEN(XLEN)) bus();
    riscv_muldiv_sequencer #(.XLEN(XLEN)) dut (.clk(clk), .reset(reset), .bus(bus));

    int tests = 0;
    int fails = 0;
    logic [63:0] last_res = '0;
    sb_t sbq[$];
    vec_t vt[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        logic ov;
        ov = a == MIN && b == ONES;
        case (f3)
            F3_MUL:    return a * b;
            F3_MULH:   begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
            F3_MULHSU: begin p = {{64{a[63]}}, a} * {64'b0, b}; return p[127:64]; end
            F3_MULHU:  begin p = {64'b0, a} * {64'b0, b}; return p[127:64]; end
            F3_DIV:    return b == 0 ? ONES : ov ? a : 64'($signed(a) / $signed(b));
            F3_DIVU:   return b == 0 ? ONES : a / b;
            F3_REM:    return b == 0 ? a : ov ? 64'd0 : 64'($signed(a) % $signed(b));
            default:   return b == 0 ? a : a % b;
        endcase
    endfunction

    task automatic quiet(input int cycles, input string name);
        int cnt = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (bus.done) cnt++;
        end
        chk(name, 64'(cnt), 64'd0);
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp, input int lat, input bit extra_start);
        int n;
        int sc;
        sb_t e;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        bus.func3 = f3;
        bus.op_a  = a;
        bus.op_b  = b;
        sbq.push_back('{exp, lat});
        #1;
        sc = int'(bus.stall);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op_a  = 64'($urandom);
        bus.op_b  = 64'($urandom);
        n = 1;
        while (!bus.done && n < 200) begin
            sc += int'(bus.stall);
            @(posedge clk);
            #1;
            n++;
            if (extra_start && n == 5) begin
                bus.start = 1'b1;
                bus.func3 = F3_MUL;
                bus.op_a  = 64'd3;
                bus.op_b  = 64'd5;
            end else bus.start = 1'b0;
        end
        bus.start = 1'b0;
        if (!bus.done) begin
            tests++;
            fails++;
            $display("FAIL timeout: no done after %0d cycles, expected one at %0d", n, lat);
        end else if (sbq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard: done with result %h but nothing outstanding", bus.result);
        end else begin
            e = sbq.pop_front();
            chk("result", bus.result, e.exp);
            chk("latency", 64'(n), 64'(e.lat));
            chk("stall_cycles", 64'(sc), 64'(e.lat));
            chk("stall_done", 64'(bus.stall), 64'd0);
            last_res = e.exp;
        end
    endtask

    initial begin
        logic [2:0] f3;
        logic [63:0] a, b, exp;
        int n;
        vt[0]  = '{F3_MUL,    64'd7,   64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 67};
        vt[1]  = '{F3_MULHU,  ONES,    ONES,                    64'hFFFF_FFFF_FFFF_FFFE, 67};
        vt[2]  = '{F3_MULH,   ONES,    ONES,                    64'd0,                   67};
        vt[3]  = '{F3_MULHSU, ONES,    ONES,                    ONES,                    67};
        vt[4]  = '{F3_DIV,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2,   64'hFFFF_FFFF_FFFF_FFFD, 67};
        vt[5]  = '{F3_REM,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2,   ONES,                    67};
        vt[6]  = '{F3_DIVU,   64'd100, 64'd7,                   64'd14,                  67};
        vt[7]  = '{F3_REMU,   64'd100, 64'd7,                   64'd2,                   67};
        vt[8]  = '{F3_DIV,    64'd5,   64'd0,                   ONES,                    2};
        vt[9]  = '{F3_REM,    64'd5,   64'd0,                   64'd5,                   2};
        vt[10] = '{F3_DIVU,   64'd5,   64'd0,                   ONES,                    2};
        vt[11] = '{F3_REMU,   64'd5,   64'd0,                   64'd5,                   2};
        vt[12] = '{F3_DIV,    MIN,     ONES,                    MIN,                     2};
        vt[13] = '{F3_REM,    MIN,     ONES,                    64'd0,                   2};
        vt[14] = '{F3_DIVU,   MIN,     ONES,                    64'd0,                   67};
        vt[15] = '{F3_REMU,   MIN,     ONES,                    MIN,                     67};
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.func3 = '0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        chk("reset_result", bus.result, 64'd0);
        chk("reset_stall", 64'(bus.stall), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 16; i++) run_op(vt[i].f3, vt[i].a, vt[i].b, vt[i].exp, vt[i].lat, 1'b0);
        for (int i = 0; i < 8; i++) begin
            f3 = 3'(i);
            a = {32'($urandom), 32'($urandom)};
            b = (i % 3 == 0) ? 64'($urandom_range(1, 1000)) : {32'($urandom), 32'($urandom)};
            exp = model(f3, a, b);
            run_op(f3, a, b, exp, 67, 1'b0);
        end
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        bus.func3 = F3_MUL;
        bus.op_a  = 64'd3;
        bus.op_b  = 64'd4;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        n = 1;
        while (n < 10) begin
            @(posedge clk);
            n++;
        end
        #1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        #1;
        chk("flush_busy", 64'(bus.busy), 64'd0);
        chk("flush_done", 64'(bus.done), 64'd0);
        chk("flush_stall", 64'(bus.stall), 64'd0);
        chk("flush_result", bus.result, last_res);
        quiet(75, "flush_no_done");
        @(posedge clk);
        run_op(F3_MUL, 64'd6, 64'd7, 64'd42, 67, 1'b0);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        bus.flush = 1'b1;
        #1;
        chk("idle_flush_stall", 64'(bus.stall), 64'd0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        chk("idle_flush_busy", 64'(bus.busy), 64'd0);
        quiet(70, "idle_flush_no_done");
        @(negedge clk);
        bus.start = 1'b1;
        bus.func3 = F3_DIVU;
        bus.op_a  = 64'd1000;
        bus.op_b  = 64'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (29) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("areset_busy", 64'(bus.busy), 64'd0);
        chk("areset_done", 64'(bus.done), 64'd0);
        chk("areset_result", bus.result, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        last_res = '0;
        quiet(80, "areset_no_done");
        run_op(F3_DIVU, 64'd100, 64'd7, 64'd14, 67, 1'b1);
        quiet(80, "ignored_start_no_done");
        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
